// File: rtl/boid_grid_pkg.sv
// Grid defaults, plotter FSM state type and cross-footprint write order for the boid plotter.
package boid_grid_pkg;

   localparam int DEF_GRID_W     = 32;
   localparam int DEF_GRID_H     = 32;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_COORD_W    = 6;
   localparam int N_OFS          = 5;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLOT       = 2'd1,
      WAIT_CLEAR = 2'd2,
      SWAP       = 2'd3
   } plot_state_t;

   // Cross cells are written in this order: centre, x-1, x+1, y-1, y+1.
   typedef enum logic [2:0] {
      OFS_C  = 3'd0,
      OFS_XM = 3'd1,
      OFS_XP = 3'd2,
      OFS_YM = 3'd3,
      OFS_YP = 3'd4
   } cross_ofs_t;

   function automatic int ofs_dx(input logic [2:0] idx);
      case (idx)
         OFS_XM:  ofs_dx = -32'sd1;
         OFS_XP:  ofs_dx = 32'sd1;
         default: ofs_dx = 32'sd0;
      endcase
   endfunction

   function automatic int ofs_dy(input logic [2:0] idx);
      case (idx)
         OFS_YM:  ofs_dy = -32'sd1;
         OFS_YP:  ofs_dy = 32'sd1;
         default: ofs_dy = 32'sd0;
      endcase
   endfunction

endpackage

// File: rtl/boid_pos_fifo.sv
// Synchronous position FIFO with full/empty flags; a push while full is taken only alongside a pop.
module boid_pos_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == DEPTH_C);
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   assign dout      = mem_r[rd_ptr_r];

   // Storage array, written at the tail on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/boid_plotter.sv
// Boid plotter: queues boid cell positions, turns each into occupancy-RAM writes and sequences
// the buffer swap. Define BOID_PLOT_CROSS_EN to plot a 5-cell cross per boid instead of one cell.
module boid_plotter
   import boid_grid_pkg::*;
#(
   parameter int GRID_W     = DEF_GRID_W,
   parameter int GRID_H     = DEF_GRID_H,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int COORD_W    = DEF_COORD_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COORD_W-1:0]    in_x,
   input  logic [COORD_W-1:0]    in_y,
   input  logic                  frame_end,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  write_data,
   output logic                  swap,
   output logic                  overrun
);

   localparam int CELLS   = GRID_W * GRID_H;
   localparam int GUARD_W = $clog2(CELLS + 1);
   localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(CELLS);
   localparam logic [GUARD_W-1:0] GUARD_ONE = GUARD_W'(32'd1);

   plot_state_t             state_r, state_next_s;
   logic [2:0]              step_r;
   logic                    pending_r, overrun_r, we_r, swap_r;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
   logic [GUARD_W-1:0]      guard_r, guard_next_s;
   logic                    push_s, pop_s, full_s, empty_s, active_s, emit_s;
   logic [2*COORD_W-1:0]    head_s;
   logic [N_OFS-1:0]        valid_mask_s;
   logic                    centre_ok_s, sel_found_s, more_s;
   logic [2:0]              sel_idx_s;
   int                      hx_s, hy_s, cell_x_s, cell_y_s;

   assign in_ready   = !full_s && !pending_r;
   assign push_s     = in_valid && in_ready;
   assign we         = we_r;
   assign write_addr = addr_r;
   assign write_data = 1'b1;
   assign swap       = swap_r;
   assign overrun    = overrun_r;

   boid_pos_fifo #(
      .WIDTH (2 * COORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .din   ({in_y, in_x}),
      .pop   (pop_s),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Footprint walk: pick the first in-grid cell of the head boid at or after step_r.
   always_comb begin
      hx_s         = int'(head_s[COORD_W-1:0]);
      hy_s         = int'(head_s[2*COORD_W-1:COORD_W]);
      centre_ok_s  = (hx_s < GRID_W) && (hy_s < GRID_H);
      valid_mask_s = {4'b0000, centre_ok_s};
`ifdef BOID_PLOT_CROSS_EN
      valid_mask_s[OFS_XM] = centre_ok_s && (hx_s > 32'sd0);
      valid_mask_s[OFS_XP] = centre_ok_s && (hx_s < GRID_W - 32'sd1);
      valid_mask_s[OFS_YM] = centre_ok_s && (hy_s > 32'sd0);
      valid_mask_s[OFS_YP] = centre_ok_s && (hy_s < GRID_H - 32'sd1);
`endif
      sel_found_s = 1'b0;
      sel_idx_s   = 3'd0;
      more_s      = 1'b0;
      for (int i = 0; i < N_OFS; i++) begin
         if (valid_mask_s[i] && (i >= int'(step_r))) begin
            if (!sel_found_s) begin
               sel_found_s = 1'b1;
               sel_idx_s   = 3'(i);
            end else begin
               more_s = 1'b1;
            end
         end else begin
            more_s = more_s;
         end
      end
      cell_x_s = hx_s + ofs_dx(sel_idx_s);
      cell_y_s = hy_s + ofs_dy(sel_idx_s);
      addr_s   = ADDR_WIDTH'(cell_y_s * GRID_W + cell_x_s);
   end

   // A boid with no in-grid cell left is popped without a write.
   assign active_s = ((state_r == IDLE) || (state_r == PLOT)) && !empty_s;
   assign emit_s   = active_s && sel_found_s;
   assign pop_s    = active_s && !more_s;
   assign guard_next_s = (guard_r == GUARD_MAX) ? guard_r : guard_r + GUARD_ONE;

   // Next-state logic for the plot / clear-wait / swap sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               state_next_s = PLOT;
            end else if (pending_r) begin
               state_next_s = WAIT_CLEAR;
            end else begin
               state_next_s = IDLE;
            end
         end
         PLOT: begin
            if (empty_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = PLOT;
            end
         end
         WAIT_CLEAR: begin
            if (guard_next_s == GUARD_MAX) begin
               state_next_s = SWAP;
            end else begin
               state_next_s = WAIT_CLEAR;
            end
         end
         SWAP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State, registered outputs, frame bookkeeping and guard counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         step_r    <= 3'd0;
         pending_r <= 1'b0;
         overrun_r <= 1'b0;
         guard_r   <= GUARD_MAX;
         we_r      <= 1'b0;
         addr_r    <= {ADDR_WIDTH{1'b0}};
         swap_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         we_r    <= emit_s;
         addr_r  <= emit_s ? addr_s : addr_r;
         swap_r  <= (state_next_s == SWAP);
         guard_r <= (state_next_s == SWAP) ? {GUARD_W{1'b0}} : guard_next_s;
         step_r  <= pop_s ? 3'd0 : (active_s ? sel_idx_s + 3'd1 : step_r);
         if (state_r == SWAP) begin
            pending_r <= 1'b0;
         end else if (frame_end) begin
            pending_r <= 1'b1;
         end else begin
            pending_r <= pending_r;
         end
         // A frame_end while one is still pending is dropped and flagged.
         overrun_r <= overrun_r | (frame_end & pending_r);
      end
   end

endmodule
